// File: rtl/keypad_event_filter_pkg.sv
// keypad_event_filter_pkg: state encoding, key width and default tick timing shared by the keypad event filter
package keypad_event_filter_pkg;
    localparam int unsigned KEY_W          = 4;
    localparam int unsigned DEF_DEB_TICKS  = 4;
    localparam int unsigned DEF_REP_DELAY  = 50;
    localparam int unsigned DEF_REP_PERIOD = 10;
    localparam int unsigned DEF_CNT_W      = 8;
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DEB_PRESS = 3'd1,
        S_HELD_DLY  = 3'd2,
        S_HELD_REP  = 3'd3,
        S_DEB_REL   = 3'd4
    } state_t;
endpackage

// File: rtl/keypad_event_filter_tick_counter.sv
// keypad_event_filter_tick_counter: saturating tick-enabled counter; clear together with inc loads 1
module keypad_event_filter_tick_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_tick && i_clr)
            r_cnt <= CNT_W'(i_inc);
        else if (i_tick && i_inc && r_cnt != '1)
            r_cnt <= r_cnt + CNT_W'(1);
    end
    assign o_cnt = r_cnt;
endmodule

// File: rtl/keypad_event_filter.sv
// keypad_event_filter: debounces raw keypad levels into one-clk press, repeat and release events timed in sample ticks
module keypad_event_filter
    import keypad_event_filter_pkg::*;
#(
    parameter int unsigned DEB_TICKS  = DEF_DEB_TICKS,
    parameter int unsigned REP_DELAY  = DEF_REP_DELAY,
    parameter int unsigned REP_PERIOD = DEF_REP_PERIOD,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [KEY_W-1:0] raw_key,
    input  logic             raw_pressed,
    output logic [KEY_W-1:0] key_code,
    output logic             key_event,
    output logic             key_repeat,
    output logic             key_held,
    output logic             key_release
);
    state_t           r_state, w_state_nxt, r_ret, w_ret_nxt, w_hs;
    logic [KEY_W-1:0] r_key_s, r_cand, w_cand_nxt, r_code, w_code_nxt;
    logic             r_pr_s, r_event, r_repeat, r_held, r_release;
    logic             w_event, w_repeat, w_held_nxt, w_release, w_clr, w_inc, w_same;
    logic [CNT_W-1:0] w_cnt, r_rel_cnt, w_rel_nxt;
    logic [CNT_W:0]   w_cnt_inc, w_rel_inc, w_lim;

    keypad_event_filter_tick_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_tick (tick),
        .i_clr  (w_clr),
        .i_inc  (w_inc),
        .o_cnt  (w_cnt)
    );

    assign w_cnt_inc = {1'b0, w_cnt} + (CNT_W+1)'(1);
    assign w_rel_inc = {1'b0, r_rel_cnt} + (CNT_W+1)'(1);
    assign w_same    = r_pr_s && (r_key_s == r_code);
    // while release-debouncing, the shared counter still holds the frozen repeat count of r_ret
    assign w_hs      = (r_state == S_DEB_REL) ? r_ret : r_state;
    assign w_lim     = (w_hs == S_HELD_DLY) ? (CNT_W+1)'(REP_DELAY) : (CNT_W+1)'(REP_PERIOD);

    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_cand_nxt  = r_cand;
        w_code_nxt  = r_code;
        w_rel_nxt   = r_rel_cnt;
        w_held_nxt  = r_held;
        w_event     = 1'b0;
        w_repeat    = 1'b0;
        w_release   = 1'b0;
        w_clr       = 1'b0;
        w_inc       = 1'b0;
        if (tick) begin
            case (r_state)
                S_IDLE: begin
                    if (r_pr_s) begin
                        w_state_nxt = S_DEB_PRESS;
                        w_cand_nxt  = r_key_s;
                        w_clr       = 1'b1;
                        w_inc       = 1'b1;
                    end
                end
                S_DEB_PRESS: begin
                    if (!r_pr_s) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_key_s != r_cand) begin
                        w_cand_nxt = r_key_s;
                        w_clr      = 1'b1;
                        w_inc      = 1'b1;
                    end else if (w_cnt_inc >= (CNT_W+1)'(DEB_TICKS)) begin
                        w_state_nxt = S_HELD_DLY;
                        w_code_nxt  = r_cand;
                        w_held_nxt  = 1'b1;
                        w_event     = 1'b1;
                        w_clr       = 1'b1;
                    end else begin
                        w_inc = 1'b1;
                    end
                end
                default: begin
                    if (!w_same && r_state != S_DEB_REL) begin
                        w_state_nxt = S_DEB_REL;
                        w_ret_nxt   = r_state;
                        w_rel_nxt   = CNT_W'(1);
                    end else if (!w_same && w_rel_inc >= (CNT_W+1)'(DEB_TICKS)) begin
                        w_state_nxt = S_IDLE;
                        w_held_nxt  = 1'b0;
                        w_release   = 1'b1;
                    end else if (!w_same) begin
                        w_rel_nxt = w_rel_inc[CNT_W-1:0];
                    end else if (w_cnt_inc >= w_lim) begin
                        w_state_nxt = S_HELD_REP;
                        w_event     = 1'b1;
                        w_repeat    = 1'b1;
                        w_clr       = 1'b1;
                    end else begin
                        w_state_nxt = w_hs;
                        w_inc       = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_s   <= '0;
            r_pr_s    <= 1'b0;
            r_state   <= S_IDLE;
            r_ret     <= S_HELD_DLY;
            r_cand    <= '0;
            r_code    <= '0;
            r_rel_cnt <= '0;
            r_held    <= 1'b0;
            r_event   <= 1'b0;
            r_repeat  <= 1'b0;
            r_release <= 1'b0;
        end else begin
            if (tick) begin
                r_key_s <= raw_key;
                r_pr_s  <= raw_pressed;
            end
            r_state   <= w_state_nxt;
            r_ret     <= w_ret_nxt;
            r_cand    <= w_cand_nxt;
            r_code    <= w_code_nxt;
            r_rel_cnt <= w_rel_nxt;
            r_held    <= w_held_nxt;
            r_event   <= w_event;
            r_repeat  <= w_repeat;
            r_release <= w_release;
        end
    end

    assign key_code    = r_code;
    assign key_event   = r_event;
    assign key_repeat  = r_repeat;
    assign key_held    = r_held;
    assign key_release = r_release;

    assert property (@(posedge clk) disable iff (rst) REP_PERIOD != 0);
endmodule

// File: tb/tb_keypad_event_filter.sv
// tb_keypad_event_filter: directed key scenarios with hand-computed event tick numbers
module tb_keypad_event_filter;
    logic       clk = 1'b0;
    logic       rst, tick, raw_pressed;
    logic [3:0] raw_key, key_code;
    logic       key_event, key_repeat, key_held, key_release;
    int n_chk = 0, n_fail = 0, tick_n = 0, bad_rep = 0, b = 0, eb = 0, rb = 0;
    int ev_t[$], ev_r[$], ev_c[$], rel_t[$], rel_c[$];

    always #5 clk = ~clk;

    keypad_event_filter dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .raw_key     (raw_key),
        .raw_pressed (raw_pressed),
        .key_code    (key_code),
        .key_event   (key_event),
        .key_repeat  (key_repeat),
        .key_held    (key_held),
        .key_release (key_release)
    );

    // every clk that shows a pulse is logged with the tick that decided it
    always @(negedge clk) begin
        if (key_event) begin
            ev_t.push_back(tick_n);
            ev_r.push_back(int'(key_repeat));
            ev_c.push_back(int'(key_code));
        end
        if (key_release) begin
            rel_t.push_back(tick_n);
            rel_c.push_back(int'(key_code));
        end
        if (key_repeat && !key_event) bad_rep++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tk(input logic p, input logic [3:0] k);
        @(negedge clk);
        raw_pressed = p;
        raw_key     = k;
        tick        = 1'b1;
        tick_n++;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic ticks(input int n, input logic p, input logic [3:0] k);
        for (int i = 0; i < n; i++) tk(p, k);
    endtask

    task automatic mark();
        @(posedge clk);
        b  = tick_n;
        eb = ev_t.size();
        rb = rel_t.size();
    endtask

    task automatic settle();
        @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; raw_pressed = 1'b0; raw_key = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_code", key_code, 0);
        chk("rst_event", key_event, 0);
        chk("rst_repeat", key_repeat, 0);
        chk("rst_held", key_held, 0);
        chk("rst_release", key_release, 0);
        rst = 1'b0; raw_pressed = 1'b1; raw_key = 4'd5;
        repeat (10) @(negedge clk);
        chk("notick_events", ev_t.size(), 0);
        chk("notick_held", key_held, 0);

        mark();
        ticks(6, 1'b1, 4'd5);
        settle();
        chk("t1_ev_n", ev_t.size() - eb, 1);
        chk("t1_ev_tick", ev_t[eb] - b, 5);
        chk("t1_ev_rep", ev_r[eb], 0);
        chk("t1_ev_code", ev_c[eb], 5);
        chk("t1_held", key_held, 1);
        mark();
        ticks(6, 1'b0, 4'd5);
        settle();
        chk("t1_rel_n", rel_t.size() - rb, 1);
        chk("t1_rel_tick", rel_t[rb] - b, 5);
        chk("t1_rel_held", key_held, 0);
        chk("t1_code_kept", key_code, 5);

        mark();
        tk(1'b1, 4'd6); tk(1'b0, 4'd6); tk(1'b1, 4'd6); tk(1'b1, 4'd6); tk(1'b0, 4'd6);
        ticks(3, 1'b0, 4'd6);
        settle();
        chk("t2_ev_n", ev_t.size() - eb, 0);
        chk("t2_rel_n", rel_t.size() - rb, 0);
        chk("t2_held", key_held, 0);
        mark();
        ticks(6, 1'b1, 4'd2);
        settle();
        chk("t2_fresh_ev_n", ev_t.size() - eb, 1);
        chk("t2_fresh_ev_tick", ev_t[eb] - b, 5);
        chk("t2_fresh_code", key_code, 2);
        ticks(6, 1'b0, 4'd2);

        mark();
        ticks(80, 1'b1, 4'd3);
        settle();
        chk("t3_ev_n", ev_t.size() - eb, 4);
        chk("t3_ev0_tick", ev_t[eb] - b, 5);
        chk("t3_ev1_tick", ev_t[eb+1] - b, 55);
        chk("t3_ev2_tick", ev_t[eb+2] - b, 65);
        chk("t3_ev3_tick", ev_t[eb+3] - b, 75);
        chk("t3_ev0_rep", ev_r[eb], 0);
        chk("t3_ev1_rep", ev_r[eb+1], 1);
        chk("t3_ev3_rep", ev_r[eb+3], 1);
        mark();
        ticks(6, 1'b0, 4'd3);
        settle();
        chk("t3_rel_n", rel_t.size() - rb, 1);
        chk("t3_rel_tick", rel_t[rb] - b, 5);
        chk("t3_rel_ev_n", ev_t.size() - eb, 0);
        chk("t3_rel_held", key_held, 0);
        chk("t3_code_kept", key_code, 3);

        mark();
        ticks(19, 1'b1, 4'd7);
        ticks(2, 1'b0, 4'd7);
        ticks(49, 1'b1, 4'd7);
        settle();
        chk("t4_rel_n", rel_t.size() - rb, 0);
        chk("t4_ev_n", ev_t.size() - eb, 3);
        chk("t4_ev0_tick", ev_t[eb] - b, 5);
        chk("t4_ev1_tick", ev_t[eb+1] - b, 57);
        chk("t4_ev2_tick", ev_t[eb+2] - b, 67);
        chk("t4_held", key_held, 1);
        mark();
        ticks(6, 1'b0, 4'd7);
        settle();
        chk("t4_rel_final", rel_t.size() - rb, 1);

        mark();
        ticks(10, 1'b1, 4'd3);
        ticks(12, 1'b1, 4'd9);
        settle();
        chk("t5_ev_n", ev_t.size() - eb, 2);
        chk("t5_ev0_code", ev_c[eb], 3);
        chk("t5_rel_n", rel_t.size() - rb, 1);
        chk("t5_rel_tick", rel_t[rb] - b, 15);
        chk("t5_rel_code", rel_c[rb], 3);
        chk("t5_ev1_tick", ev_t[eb+1] - b, 19);
        chk("t5_ev1_code", ev_c[eb+1], 9);
        chk("t5_ev1_rep", ev_r[eb+1], 0);
        chk("t5_held", key_held, 1);
        ticks(6, 1'b0, 4'd9);

        mark();
        ticks(58, 1'b1, 4'd4);
        settle();
        chk("t6_ev_n", ev_t.size() - eb, 2);
        chk("t6_held_pre", key_held, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_held", key_held, 0);
        chk("t6_async_code", key_code, 0);
        chk("t6_async_event", key_event, 0);
        @(negedge clk);
        rst = 1'b0;
        mark();
        ticks(6, 1'b1, 4'd4);
        settle();
        chk("t6_rel_n", rel_t.size() - rb, 0);
        chk("t6_ev_n_after", ev_t.size() - eb, 1);
        chk("t6_ev_tick_after", ev_t[eb] - b, 5);
        chk("t6_ev_rep_after", ev_r[eb], 0);

        chk("repeat_only_with_event", bad_rep, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
